// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage and the external data memory.
// The stage is the master: it raises req and waits for ack.
// For reads, rdata is valid in the same cycle as ack.
interface mem_access_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        be;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ack, rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline.
// Performs loads and stores over a req/ack data-memory bus.
// While an access is outstanding it stalls the upstream stages and sends a bubble to MEM/WB.
module mem_access_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_ex_mem_mem_read,
    input  logic              i_ex_mem_mem_write,
    input  logic [1:0]        i_ex_mem_size,
    input  logic              i_ex_mem_unsigned,
    input  logic [ADDR_W-1:0] i_ex_mem_alu_res,
    input  logic [DATA_W-1:0] i_ex_mem_write_data,
    input  logic [1:0]        i_ex_mem_wb,
    input  logic [4:0]        i_ex_mem_reg_dest,
    mem_access_stage_if.master dmem,
    output logic              o_mem_stall,
    output logic [1:0]        o_mem_wb_out,
    output logic [DATA_W-1:0] o_mem_read_data,
    output logic [ADDR_W-1:0] o_mem_alu_res,
    output logic [4:0]        o_mem_reg_dest,
    output logic              o_mem_misalign
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [DATA_W-1:0] r_read_data;
    logic              w_access;
    logic              w_aligned;
    logic [DATA_W-1:0] w_wdata;
    logic [3:0]        w_store_be;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load_fmt;

    assign w_access = i_ex_mem_mem_read | i_ex_mem_mem_write;

    // Alignment check: a byte is always aligned; a half needs an even address; a word (or size 11) needs a multiple of 4.
    always_comb begin
        w_aligned = 1'b1;
        case (i_ex_mem_size)
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~i_ex_mem_alu_res[0];
            default: w_aligned = (i_ex_mem_alu_res[1:0] == 2'b00);
        endcase
    end

    // Store steering: replicate the store data across the lanes, and set the byte enables for the addressed lanes.
    always_comb begin
        w_wdata    = i_ex_mem_write_data;
        w_store_be = 4'b1111;
        case (i_ex_mem_size)
            2'b00: begin
                w_wdata    = {4{i_ex_mem_write_data[7:0]}};
                w_store_be = 4'b0001 << i_ex_mem_alu_res[1:0];
            end
            2'b01: begin
                w_wdata    = {2{i_ex_mem_write_data[15:0]}};
                w_store_be = i_ex_mem_alu_res[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wdata    = i_ex_mem_write_data;
                w_store_be = 4'b1111;
            end
        endcase
    end

    // Load extraction: pick the addressed lane, then sign-extend or zero-extend it to the full width.
    always_comb begin
        w_byte     = dmem.rdata[7:0];
        w_half     = i_ex_mem_alu_res[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
        w_load_fmt = dmem.rdata;
        case (i_ex_mem_alu_res[1:0])
            2'b00:   w_byte = dmem.rdata[7:0];
            2'b01:   w_byte = dmem.rdata[15:8];
            2'b10:   w_byte = dmem.rdata[23:16];
            default: w_byte = dmem.rdata[31:24];
        endcase
        case (i_ex_mem_size)
            2'b00:   w_load_fmt = i_ex_mem_unsigned ? {24'd0, w_byte}
                                                    : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load_fmt = i_ex_mem_unsigned ? {16'd0, w_half}
                                                    : {{16{w_half[15]}}, w_half};
            default: w_load_fmt = dmem.rdata;
        endcase
    end

    // FSM next state and stage outputs.
    // During reset, stall and misalign are forced low, even though the inputs keep changing.
    always_comb begin
        w_next_state   = r_state;
        o_mem_stall    = 1'b0;
        o_mem_misalign = 1'b0;
        o_mem_wb_out   = i_ex_mem_wb;
        case (r_state)
            IDLE: begin
                if (w_access && w_aligned) begin
                    o_mem_stall  = 1'b1;
                    o_mem_wb_out = 2'b00;
                    w_next_state = BUSY;
                end else if (w_access) begin
                    o_mem_misalign = 1'b1;
                    o_mem_wb_out   = 2'b00;
                end
            end
            BUSY: begin
                o_mem_stall  = 1'b1;
                o_mem_wb_out = 2'b00;
                if (dmem.ack) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        if (!rst_n) begin
            o_mem_stall    = 1'b0;
            o_mem_misalign = 1'b0;
        end
    end

    // State register, plus capture of the formatted load data when a read is acknowledged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_read_data <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == BUSY && dmem.ack && !i_ex_mem_mem_write) begin
                r_read_data <= w_load_fmt;
            end
        end
    end

    assign dmem.req        = (r_state == BUSY);
    assign dmem.we         = (r_state == BUSY) & i_ex_mem_mem_write;
    assign dmem.addr       = {i_ex_mem_alu_res[ADDR_W-1:2], 2'b00};
    assign dmem.wdata      = w_wdata;
    assign dmem.be         = dmem.we ? w_store_be : 4'b1111;
    assign o_mem_read_data = r_read_data;
    assign o_mem_alu_res   = i_ex_mem_alu_res;
    assign o_mem_reg_dest  = i_ex_mem_reg_dest;

endmodule
